// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared constants and RX state encoding for io_port_bridge
package io_bridge_pkg;

    localparam int DATA_W     = 8;
    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/io_bridge_fifo.sv
// rtl/io_bridge_fifo.sv - synchronous transmit FIFO with accept-when-full-with-pop
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_push, i_data  write request and byte
//   i_pop           pop request (ignored while empty)
//   o_head          byte at the read pointer
//   o_count         occupancy, 0..DEPTH
//   o_full          o_count == DEPTH
//   o_drop          push rejected this cycle (full and no pop)
module io_bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_accept;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = i_pop && (r_count != '0);
    // When full, a same-cycle pop frees the slot the write pointer is on,
    // so the push can land there while the old byte leaves via o_head.
    assign w_accept = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_accept) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_drop  = i_push && !w_accept;

endmodule

// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - processor In/Out register bridge to device valid/ready streams
//
// Optional macro IOBRIDGE_OVF_CNT_EN adds the saturating drop_count output.
//
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   cpu_we, cpu_out              processor OUT register write, pushed into TX FIFO
//   cpu_in, cpu_rx_ack           held RX byte to processor IN register, consume pulse
//   tx_data, tx_valid, tx_ready  FIFO head to device
//   rx_data, rx_valid, rx_ready  byte from device into the holding register
//   tx_count, tx_full            FIFO occupancy and full flag
//   overrun                      sticky: a processor write was dropped
//   drop_count                   (IOBRIDGE_OVF_CNT_EN) saturating dropped-write count
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_we,
    input  logic [DATA_W-1:0]        cpu_out,
    output logic [DATA_W-1:0]        cpu_in,
    input  logic                     cpu_rx_ack,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_full,
    output logic                     overrun
`ifdef IOBRIDGE_OVF_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_count
`endif
);

    logic [$clog2(DEPTH):0] w_count;
    logic                   w_drop;
    logic                   w_tx_valid;
    rx_state_t              r_rx_state;
    logic [DATA_W-1:0]      r_cpu_in;
    logic                   r_overrun;

    assign w_tx_valid = (w_count != '0);

    io_bridge_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cpu_we),
        .i_data  (cpu_out),
        .i_pop   (w_tx_valid && tx_ready),
        .o_head  (tx_data),
        .o_count (w_count),
        .o_full  (tx_full),
        .o_drop  (w_drop)
    );

    assign tx_valid = w_tx_valid;
    assign tx_count = w_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_EMPTY;
            r_cpu_in   <= '0;
        end else begin
            case (r_rx_state)
                RX_EMPTY: begin
                    if (rx_valid) begin
                        r_cpu_in   <= rx_data;
                        r_rx_state <= RX_FULL;
                    end
                end
                RX_FULL: begin
                    if (cpu_rx_ack) r_rx_state <= RX_EMPTY;
                end
                default: r_rx_state <= RX_EMPTY;
            endcase
        end
    end

    // Gated by rst so the device sees no acceptance while reset is held.
    assign rx_ready = (r_rx_state == RX_EMPTY) && !rst;
    assign cpu_in   = r_cpu_in;

    always_ff @(posedge clk) begin
        if (rst)         r_overrun <= 1'b0;
        else if (w_drop) r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;

`ifdef IOBRIDGE_OVF_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_count <= '0;
        else if (w_drop && (r_drop_count != '1))
            r_drop_count <= r_drop_count + 1'b1;
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// tb/tb_io_port_bridge.sv - directed self-checking bench for io_port_bridge
module tb_io_port_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_we;
    logic [7:0] cpu_out;
    logic [7:0] cpu_in;
    logic       cpu_rx_ack;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] tx_count;
    logic       tx_full;
    logic       overrun;
`ifdef IOBRIDGE_OVF_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    io_port_bridge #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_out    (cpu_out),
        .cpu_in     (cpu_in),
        .cpu_rx_ack (cpu_rx_ack),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_count   (tx_count),
        .tx_full    (tx_full),
        .overrun    (overrun)
`ifdef IOBRIDGE_OVF_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        cpu_we  = 1'b1;
        cpu_out = b;
        tick();
        cpu_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_we = 0; cpu_out = 0; cpu_rx_ack = 0;
        tx_ready = 0; rx_data = 0; rx_valid = 0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1'($urandom); cpu_out = 8'($urandom);
            cpu_rx_ack = 1'($urandom); tx_ready = 1'($urandom);
            rx_data = 8'($urandom); rx_valid = 1'($urandom);
            tick();
        end
        check("rst_cpu_in",   cpu_in,   8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_count", tx_count, 3'd0);
        check("rst_overrun",  overrun,  1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_tx_full",  tx_full,  1'b0);
        cpu_we = 0; cpu_out = 0; cpu_rx_ack = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
        rst = 1'b0;
        tick();
        check("post_rst_rx_ready", rx_ready, 1'b1);
        check("post_rst_tx_valid", tx_valid, 1'b0);

        // ack in RX_EMPTY is ignored
        cpu_rx_ack = 1'b1;
        tick();
        cpu_rx_ack = 1'b0;
        check("ack_empty_rx_ready", rx_ready, 1'b1);

        // TX basic
        cpu_we = 1'b1; cpu_out = 8'hA5;
        #2;
        check("tx_no_bypass", tx_valid, 1'b0);
        tick();
        check("tx_valid_rise", tx_valid, 1'b1);
        check("tx_head_a5", tx_data, 8'hA5);
        push(8'h3C);
        check("tx_count_2", tx_count, 3'd2);
        tick();
        check("tx_hold_a5", tx_data, 8'hA5);
        tx_ready = 1'b1;
        tick();
        check("tx_head_3c", tx_data, 8'h3C);
        check("tx_count_1", tx_count, 3'd1);
        tick();
        check("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // full and drop
        for (int k = 1; k <= 4; k++) push(8'(k));
        check("full_flag_4", tx_full, 1'b1);
        check("no_ovr_yet", overrun, 1'b0);
        push(8'h05);
        check("drop_count_4", tx_count, 3'd4);
        check("drop_full",    tx_full,  1'b1);
        check("drop_overrun", overrun,  1'b1);
`ifdef IOBRIDGE_OVF_CNT_EN
        check("drop_cnt_1", drop_count, 8'd1);
`endif
        tx_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_%0d", k), tx_data, 8'(k));
            tick();
        end
        check("drain_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // full with simultaneous push and pop
        for (int k = 0; k < 4; k++) push(8'h0A + 8'(k));
        tx_ready = 1'b1;
        push(8'h06);
        check("fpp_count", tx_count, 3'd4);
        check("fpp_full",  tx_full,  1'b1);
        check("fpp_ovr_sticky", overrun, 1'b1);
`ifdef IOBRIDGE_OVF_CNT_EN
        check("fpp_cnt_same", drop_count, 8'd1);
`endif
        begin
            logic [7:0] exp_q [4];
            exp_q = '{8'h0B, 8'h0C, 8'h0D, 8'h06};
            for (int k = 0; k < 4; k++) begin
                check($sformatf("fpp_drain_%0d", k), tx_data, exp_q[k]);
                tick();
            end
        end
        check("fpp_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // push and pop together when not full
        push(8'h21);
        tx_ready = 1'b1;
        push(8'h22);
        check("pp_count", tx_count, 3'd1);
        check("pp_head",  tx_data,  8'h22);
        tick();
        tx_ready = 1'b0;

        // RX handshake
        rx_valid = 1'b1; rx_data = 8'h7E;
        tick();
        check("rx_cap_7e",   cpu_in,   8'h7E);
        check("rx_ready_lo", rx_ready, 1'b0);
        rx_data = 8'h11;
        tick();
        check("rx_hold_7e", cpu_in, 8'h7E);
        cpu_rx_ack = 1'b1;
        tick();
        cpu_rx_ack = 1'b0;
        check("rx_ack_ready", rx_ready, 1'b1);
        check("rx_retain",    cpu_in,   8'h7E);
        tick();
        check("rx_cap_11",    cpu_in,   8'h11);
        check("rx_ready_lo2", rx_ready, 1'b0);
        rx_valid = 1'b0;

        // reset mid-operation
        push(8'h31); push(8'h32); push(8'h33);
        check("mid_count_3", tx_count, 3'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_rx_ready", rx_ready, 1'b0);
        check("mid_rst_count",    tx_count, 3'd0);
        check("mid_rst_cpu_in",   cpu_in,   8'h00);
        check("mid_rst_overrun",  overrun,  1'b0);
        rst = 1'b0;
        tick();
        check("mid_rel_rx_ready", rx_ready, 1'b1);
        check("mid_rel_tx_valid", tx_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Peripheral-side counterpart of the processor's In/Out register.
- Drains bytes the processor writes to its OUT register into a small transmit FIFO. Presents them to an external device on a valid/ready interface.
- Accepts bytes from an external device on a valid/ready interface, holds them, and drives them onto the processor's IN register input.

Parameters:
- DEPTH, 4: transmit FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- cpu_we  in  1  processor write-enable to its OUT register (WEinOut)
- cpu_out  in  8  processor OUT register value
- cpu_in  out  8  value fed to the processor IN register
- cpu_rx_ack  in  1  processor has consumed cpu_in; one-cycle pulse
- tx_data  out  8  FIFO head byte to device
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  device accepts tx_data
- rx_data  in  8  byte from device
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  bridge can accept rx_data
- tx_count  out  $clog2(DEPTH)+1  FIFO occupancy
- tx_full  out  1  tx_count == DEPTH
- overrun  out  1  sticky flag: a processor write was dropped

Behaviour:
- Reset values: cpu_in=0, tx_valid=0, tx_count=0, tx_full=0, overrun=0, rx_ready=0 while rst is high. Read/write pointers are 0. RX state is RX_EMPTY.
- Push timing: the processor OUT register updates on negedge in the cycle where cpu_we is high. The bridge pushes cpu_out at the posedge that ends that cycle. A cpu_we held for N cycles pushes N entries.
- Pop: a pop occurs on any posedge where tx_valid && tx_ready.
- tx_valid = (tx_count != 0). tx_data is the FIFO head. No bypass: a push into an empty FIFO appears on tx_data/tx_valid one cycle later.
- While tx_valid && !tx_ready, tx_data must stay stable.
- Push while full with no pop: the byte is dropped, overrun is set, and count is unchanged.
- Push while full with a simultaneous pop: the push is accepted and count stays at DEPTH.
- Push and pop together when not full: count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- overrun clears only on rst.
- RX state machine, RX_EMPTY:
  - rx_ready=1.
  - If rx_valid, capture rx_data into cpu_in and go to RX_FULL.
  - cpu_rx_ack is ignored in this state.
- RX state machine, RX_FULL:
  - rx_ready=0.
  - If cpu_rx_ack, go to RX_EMPTY; rx_ready returns high the next cycle.
  - cpu_in retains its last value after ack.
- rx_ready is decoded from state only (RX_EMPTY && !rst). It has no combinational path from rx_valid or cpu_rx_ack.
- Reset asserted mid-operation: all queued TX bytes are discarded and a held RX byte is lost. The first cycle after rst deasserts has rx_ready=1 and tx_valid=0.

Optional Feature:
- Macro: IOBRIDGE_OVF_CNT_EN.
- Defined: adds output port drop_count [7:0], reset to 0. It increments on every dropped processor write and saturates at 255. overrun still behaves as specified.
- Undefined: drop_count port and counter are absent; only the sticky overrun exists.

Decomposition:
- Package io_bridge_pkg: DATA_W=8 constant; RX state encoding (RX_EMPTY=1'b0, RX_FULL=1'b1); DROP_CNT_W=8.
- Sub-module io_bridge_fifo: parameterised DEPTH synchronous FIFO with push, pop, head, count, full, and the accept-when-full-with-pop rule.
- The RX holding register and the optional counter stay in the top level.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> cpu_in=0, tx_valid=0, tx_count=0, overrun=0, rx_ready=0. One cycle after release -> rx_ready=1.
- TX basic: cpu_we pulses with 0xA5 then 0x3C, tx_ready=0.
  - tx_valid rises 1 cycle after the first push; tx_data=0xA5 held stable; tx_count=2.
  - Then tx_ready=1 -> 0xA5 then 0x3C pop on consecutive cycles, then tx_valid=0.
- Full/drop: DEPTH=4, push 0x01..0x04, then push 0x05 with tx_ready=0.
  - 0x05 is dropped; tx_full=1; overrun=1; drop_count=1 with IOBRIDGE_OVF_CNT_EN.
  - Drain yields 0x01..0x04 only.
- Full with simultaneous push and pop: with 4 entries, push 0x06 while tx_ready=1 -> tx_count stays 4 and the drain order ends with 0x06.
- RX handshake:
  - rx_valid with 0x7E -> cpu_in=0x7E and rx_ready=0 next cycle.
  - 0x11 presented with rx_valid held -> not captured.
  - cpu_rx_ack pulse -> rx_ready=1 the next cycle, then 0x11 captured.
- Reset mid-operation: 3 TX bytes queued and an RX byte held, then assert rst for 1 cycle -> FIFO empty, rx_ready=1 after release, cpu_in=0.
